// File: rtl/ysyx_23060240_lsu_ctrl.sv
// ysyx_23060240_lsu_ctrl
// Load/store controller between the execute stage and the LSU SRAM port.
// One op in flight; IDLE -> REQ -> DATA (loads only) -> RESP.
// Every output is a register loaded from the next-state logic, so the SRAM
// request, the write-back handshake and the tag/data lanes change only on clk.
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned H/HU/W
// accesses (no SRAM request, out_err=1). Without it, out_err stays 0 and
// misaligned ops issue with the upper lanes truncated.
module ysyx_23060240_lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic [31:0] mem_raddr,
    output logic        mem_r_en,
    output logic [31:0] mem_waddr,
    output logic [7:0]  mem_wmask,
    output logic        mem_w_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;

    // Latched op context (only what later states actually need)
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic [4:0]  rd_r;
    logic        is_load_r;
    logic        lat_en_s;

    // Output registers and their next values
    logic        in_ready_r,  in_ready_nx_s;
    logic [31:0] mem_raddr_r, mem_raddr_nx_s;
    logic        mem_r_en_r,  mem_r_en_nx_s;
    logic [31:0] mem_waddr_r, mem_waddr_nx_s;
    logic [7:0]  mem_wmask_r, mem_wmask_nx_s;
    logic        mem_w_en_r,  mem_w_en_nx_s;
    logic [31:0] mem_wdata_r, mem_wdata_nx_s;
    logic        out_valid_r, out_valid_nx_s;
    logic [31:0] out_rdata_r, out_rdata_nx_s;
    logic [4:0]  out_rd_r,    out_rd_nx_s;
    logic        out_err_r,   out_err_nx_s;

    logic        misalign_s;
    logic [31:0] align_addr_s;
    logic [1:0]  in_off_s;

    // Byte-lane mask for a store of the given width at byte offset off.
    function automatic logic [3:0] store_mask_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Shift the returned word down to the addressed byte, then extend.
    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic misalign_f(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3)
            3'b001, 3'b101: m = off[0];
            3'b010:         m = (off != 2'b00);
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

    assign misalign_s = misalign_f(in_funct3, in_addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    assign in_off_s     = in_addr[1:0];
    assign align_addr_s = {in_addr[31:2], 2'b00};

    // Next-state and next-output decode; every output defaults to 0.
    always_comb begin
        state_nx_s     = state_r;
        lat_en_s       = 1'b0;
        mem_raddr_nx_s = 32'h0000_0000;
        mem_r_en_nx_s  = 1'b0;
        mem_waddr_nx_s = 32'h0000_0000;
        mem_wmask_nx_s = 8'h00;
        mem_w_en_nx_s  = 1'b0;
        mem_wdata_nx_s = 32'h0000_0000;
        out_valid_nx_s = 1'b0;
        out_rdata_nx_s = 32'h0000_0000;
        out_rd_nx_s    = 5'd0;
        out_err_nx_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    lat_en_s = 1'b1;
                    if ((in_is_load || in_is_store) && misalign_s) begin
                        state_nx_s     = S_RESP;
                        out_valid_nx_s = 1'b1;
                        out_rd_nx_s    = in_rd;
                        out_err_nx_s   = 1'b1;
                    end else if (in_is_load) begin
                        state_nx_s     = S_REQ;
                        mem_r_en_nx_s  = 1'b1;
                        mem_raddr_nx_s = align_addr_s;
                    end else if (in_is_store) begin
                        state_nx_s     = S_REQ;
                        mem_w_en_nx_s  = 1'b1;
                        mem_waddr_nx_s = align_addr_s;
                        mem_wmask_nx_s = {4'b0000, store_mask_f(in_funct3, in_off_s)};
                        mem_wdata_nx_s = in_wdata << {in_off_s, 3'b000};
                    end else begin
                        // Neither load nor store: complete immediately with zero data
                        state_nx_s     = S_RESP;
                        out_valid_nx_s = 1'b1;
                        out_rd_nx_s    = in_rd;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (is_load_r) begin
                    state_nx_s = S_DATA;
                end else begin
                    state_nx_s     = S_RESP;
                    out_valid_nx_s = 1'b1;
                    out_rd_nx_s    = rd_r;
                end
            end
            S_DATA: begin
                state_nx_s     = S_RESP;
                out_valid_nx_s = 1'b1;
                out_rd_nx_s    = rd_r;
                out_rdata_nx_s = load_ext_f(f3_r, off_r, mem_rdata);
            end
            S_RESP: begin
                if (out_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    out_valid_nx_s = 1'b1;
                    out_rdata_nx_s = out_rdata_r;
                    out_rd_nx_s    = out_rd_r;
                    out_err_nx_s   = out_err_r;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
        in_ready_nx_s = (state_nx_s == S_IDLE);
    end

    // State and registered outputs; reset returns to IDLE and drops any pending op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            mem_raddr_r <= 32'h0000_0000;
            mem_r_en_r  <= 1'b0;
            mem_waddr_r <= 32'h0000_0000;
            mem_wmask_r <= 8'h00;
            mem_w_en_r  <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_rdata_r <= 32'h0000_0000;
            out_rd_r    <= 5'd0;
            out_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            mem_raddr_r <= mem_raddr_nx_s;
            mem_r_en_r  <= mem_r_en_nx_s;
            mem_waddr_r <= mem_waddr_nx_s;
            mem_wmask_r <= mem_wmask_nx_s;
            mem_w_en_r  <= mem_w_en_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_rdata_r <= out_rdata_nx_s;
            out_rd_r    <= out_rd_nx_s;
            out_err_r   <= out_err_nx_s;
        end
    end

    // Capture the op context when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_r      <= 3'b000;
            off_r     <= 2'b00;
            rd_r      <= 5'd0;
            is_load_r <= 1'b0;
        end else if (lat_en_s) begin
            f3_r      <= in_funct3;
            off_r     <= in_off_s;
            rd_r      <= in_rd;
            is_load_r <= in_is_load;
        end else begin
            f3_r      <= f3_r;
            off_r     <= off_r;
            rd_r      <= rd_r;
            is_load_r <= is_load_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_raddr = mem_raddr_r;
    assign mem_r_en  = mem_r_en_r;
    assign mem_waddr = mem_waddr_r;
    assign mem_wmask = mem_wmask_r;
    assign mem_w_en  = mem_w_en_r;
    assign mem_wdata = mem_wdata_r;
    assign out_valid = out_valid_r;
    assign out_rdata = out_rdata_r;
    assign out_rd    = out_rd_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_ysyx_23060240_lsu_ctrl.sv
// Self-checking bench for ysyx_23060240_lsu_ctrl: a table of directed ops
// plus hand-written sequences for write-back stall and reset mid-load.
module tb_ysyx_23060240_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_r_en, mem_w_en;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060240_lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_raddr(mem_raddr), .mem_r_en(mem_r_en),
        .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_w_en(mem_w_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_rd(out_rd), .out_err(out_err)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [7:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_out;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = 32'h0;
        in_wdata    = 32'h0;
        in_rd       = 5'd0;
    endtask

    // Accept one op; returns after the cycle in which it is first in REQ/RESP.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_funct3 = f3; in_addr = addr; in_wdata = wd; in_rd = rd;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    // Drive one table entry through the whole handshake and check every stage.
    task automatic run_vec(input vec_t v);
        int n;
        mem_rdata = v.rdata;
        @(negedge clk);
        chk({v.name, ".in_ready_before"}, {31'd0, in_ready}, 32'd1);
        issue(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
        chk({v.name, ".r_en"}, {31'd0, mem_r_en}, {31'd0, v.e_ren});
        chk({v.name, ".w_en"}, {31'd0, mem_w_en}, {31'd0, v.e_wen});
        chk({v.name, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        if (v.e_ren) chk({v.name, ".raddr"}, mem_raddr, v.e_addr);
        if (v.e_wen) begin
            chk({v.name, ".waddr"}, mem_waddr, v.e_addr);
            chk({v.name, ".wmask"}, {24'd0, mem_wmask}, {24'd0, v.e_mask});
            chk({v.name, ".wdata"}, mem_wdata, v.e_wdata);
        end
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({v.name, ".latency"}, n, v.e_lat);
        chk({v.name, ".out_rdata"}, out_rdata, v.e_out);
        chk({v.name, ".out_rd"}, {27'd0, out_rd}, {27'd0, v.rd});
        chk({v.name, ".out_err"}, {31'd0, out_err}, {31'd0, v.e_err});
        chk({v.name, ".mem_idle_resp"}, {30'd0, mem_r_en, mem_w_en}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, ".out_valid_after"}, {31'd0, out_valid}, 32'd0);
        chk({v.name, ".in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        idle_inputs();
        out_ready = 1'b0;
        mem_rdata = 32'h0;
        rst = 1'b1;

        //        name    ld    st    f3      addr          wdata         rd     rdata         ren   wen   e_addr        mask    e_wdata       e_out         err   lat
        vecs.push_back('{"sw",    1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd5,  32'h0,        1'b0, 1'b1, 32'h8000_0004, 8'h0F, 32'hDEAD_BEEF, 32'h0,        1'b0, 2});
        vecs.push_back('{"sb",    1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd6,  32'h0,        1'b0, 1'b1, 32'h8000_0000, 8'h08, 32'hA500_0000, 32'h0,        1'b0, 2});
        vecs.push_back('{"sh",    1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 5'd7,  32'h0,        1'b0, 1'b1, 32'h8000_0000, 8'h0C, 32'hBEEF_0000, 32'h0,        1'b0, 2});
        vecs.push_back('{"sb1",   1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_5677, 5'd8,  32'h0,        1'b0, 1'b1, 32'h8000_0000, 8'h02, 32'h3456_7700, 32'h0,        1'b0, 2});
        vecs.push_back('{"lb",    1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0,         5'd10, 32'h12F4_5678, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'hFFFF_FFF4, 1'b0, 3});
        vecs.push_back('{"lbu",   1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0,         5'd11, 32'h12F4_5678, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'h0000_00F4, 1'b0, 3});
        vecs.push_back('{"lh",    1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,         5'd12, 32'h12F4_5678, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'h0000_12F4, 1'b0, 3});
        vecs.push_back('{"lh_neg",1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0,         5'd13, 32'h0000_8001, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'hFFFF_8001, 1'b0, 3});
        vecs.push_back('{"lhu",   1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,         5'd14, 32'h0000_8001, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'h0000_8001, 1'b0, 3});
        vecs.push_back('{"lw",    1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0,         5'd15, 32'hCAFE_BABE, 1'b1, 1'b0, 32'h8000_0008, 8'h00, 32'h0,         32'hCAFE_BABE, 1'b0, 3});
        vecs.push_back('{"noop",  1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,         5'd7,  32'h0,        1'b0, 1'b0, 32'h0,        8'h00, 32'h0,         32'h0,        1'b0, 1});
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back('{"lw_mis",1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0,         5'd3,  32'h1122_3344, 1'b0, 1'b0, 32'h0,        8'h00, 32'h0,         32'h0,        1'b1, 1});
        vecs.push_back('{"sh_mis",1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 5'd4,  32'h0,        1'b0, 1'b0, 32'h0,        8'h00, 32'h0,         32'h0,        1'b1, 1});
`else
        vecs.push_back('{"lw_mis",1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0,         5'd3,  32'h1122_3344, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         32'h0011_2233, 1'b0, 3});
        vecs.push_back('{"sh_mis",1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 5'd4,  32'h0,        1'b0, 1'b1, 32'h8000_0000, 8'h08, 32'hEF00_0000, 32'h0,        1'b0, 2});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.mem_en", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        chk("rst.out_rdata", out_rdata, 32'd0);
        chk("rst.out_err", {31'd0, out_err}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Write-back stall: result must hold for 5 cycles with out_ready low
        mem_rdata = 32'h55AA_55AA;
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd9);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("stall.latency", n, 3);
        mem_rdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 5; k++) begin
            chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall.out_rdata", out_rdata, 32'h55AA_55AA);
            chk("stall.out_rd", {27'd0, out_rd}, 32'd9);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall.out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("stall.in_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset while in DATA: back to IDLE with nothing pending
        mem_rdata = 32'h1234_5678;
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd2);
        chk("rstd.req_r_en", {31'd0, mem_r_en}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstd.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstd.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstd.mem_en", {30'd0, mem_r_en, mem_w_en}, 32'd0);
        chk("rstd.mem_raddr", mem_raddr, 32'd0);
        chk("rstd.mem_waddr", mem_waddr, 32'd0);
        chk("rstd.mem_wmask", {24'd0, mem_wmask}, 32'd0);
        chk("rstd.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rstd.out_valid_later", {31'd0, out_valid}, 32'd0);
        chk("rstd.in_ready_later", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
